// File: rtl/ula_pkg.sv
// ula_pkg: shared constants and types for the ula arithmetic unit.
//   WIDTH   default operand/result width
//   OP_ADD  operation code for addition
//   OP_MUL  operation code for multiplication
//   state_e top-level FSM state
package ula_pkg;

  localparam int unsigned WIDTH = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic {
    StIdle,
    StMul
  } state_e;

endpackage

// File: rtl/ula_if.sv
// ula_if: request/result bundle between a requester and the ula.
//   start, h, a, b      : request (requester -> ula)
//   result, done, busy  : response (ula -> requester)
// Modports: master (requester side), slave (ula side).
interface ula_if #(
  parameter int unsigned WIDTH = ula_pkg::WIDTH
) ();

  logic             start;
  logic             h;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;

  modport master (
    output start, h, a, b,
    input  result, done, busy
  );

  modport slave (
    input  start, h, a, b,
    output result, done, busy
  );

endinterface

// File: rtl/ula_mul_seq.sv
// ula_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : capture operands and clear the accumulator
//   mcand_i      : multiplicand
//   mplier_i     : multiplier
//   product_o    : low WIDTH bits of the product; valid while finish_o is high
//   finish_o     : high during the last iteration, before the final edge
module ula_mul_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] product_o,
  output logic             finish_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [WIDTH-1:0] acc_step;
  logic             last;

  assign last = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
      if (last) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  // The final accumulation is forwarded so the top can register it on the last edge.
  assign product_o = acc_step;
  assign finish_o  = active_q && last;

endmodule

// File: rtl/ula.sv
// ula: add or multiply two unsigned operands, selected by h.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ula_if slave (start/h/a/b in; result/done/busy out)
// Add: operands captured with start, result and done one edge later.
// Multiply: WIDTH iterations in ula_mul_seq; busy high meanwhile.
module ula
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = ula_pkg::WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  ula_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             add_pend_q, add_pend_d;
  logic             mul_load;
  logic [WIDTH-1:0] mul_product;
  logic             mul_finish;
  logic             accept;

  assign accept = (state_q == StIdle) && bus.start;

  ula_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (mul_load),
    .mcand_i   (bus.a),
    .mplier_i  (bus.b),
    .product_o (mul_product),
    .finish_o  (mul_finish)
  );

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    mul_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && bus.h == OP_MUL) begin
          mul_load = 1'b1;
          state_d  = StMul;
        end
      end
      StMul: begin
        if (mul_finish) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output registers. An accepted add is computed from the
  // captured operands on the following edge, so a pending add and a freshly
  // accepted request never collide on the same register.
  always_comb begin
    result_d   = result_q;
    done_d     = 1'b0;
    opa_d      = opa_q;
    opb_d      = opb_q;
    add_pend_d = 1'b0;
    if (accept && bus.h == OP_ADD) begin
      opa_d      = bus.a;
      opb_d      = bus.b;
      add_pend_d = 1'b1;
    end
    if (add_pend_q) begin
      result_d = opa_q + opb_q;
      done_d   = 1'b1;
    end else if (state_q == StMul && mul_finish) begin
      result_d = mul_product;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      result_q   <= '0;
      done_q     <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      add_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      done_q     <= done_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      add_pend_q <= add_pend_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q == StMul);

endmodule

// File: tb/tb_ula.sv
// tb_ula: directed self-checking bench for ula at the default 16-bit width.
module tb_ula;
  import ula_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ula_if bus ();

  ula dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    @(negedge clk);
    bus.start = 1'b1;
    bus.h     = OP_ADD;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    check("add_busy", 16'(bus.busy), 16'd0);
    @(posedge clk);
    #1;
    check("add_result", bus.result, exp);
    check("add_done", 16'(bus.done), 16'd1);
    check("add_busy_end", 16'(bus.busy), 16'd0);
    @(posedge clk);
    #1;
    check("add_done_clr", 16'(bus.done), 16'd0);
    check("add_hold", bus.result, exp);
  endtask

  task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp,
                        input bit inject);
    @(negedge clk);
    bus.start = 1'b1;
    bus.h     = OP_MUL;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.h     = OP_ADD;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    check("mul_busy_first", 16'(bus.busy), 16'd1);
    for (int i = 1; i < 16; i++) begin
      if (inject && i == 5) begin
        bus.start = 1'b1;
        bus.h     = OP_ADD;
        bus.a     = 16'h0001;
        bus.b     = 16'h0001;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("mul_busy_mid", 16'(bus.busy), 16'd1);
      check("mul_done_early", 16'(bus.done), 16'd0);
    end
    @(posedge clk);
    #1;
    check("mul_result", bus.result, exp);
    check("mul_done", 16'(bus.done), 16'd1);
    check("mul_busy_end", 16'(bus.busy), 16'd0);
    @(posedge clk);
    #1;
    check("mul_done_clr", 16'(bus.done), 16'd0);
    check("mul_hold", bus.result, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.h     = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    check("rst_result", bus.result, 16'h0000);
    check("rst_done", 16'(bus.done), 16'd0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_add(16'h0060, 16'h0003, 16'h0063);
    do_mul(16'h0060, 16'h0003, 16'h0120, 1'b0);
    do_mul(16'h0004, 16'h0003, 16'h000C, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold", bus.result, 16'h000C);
    check("idle_done", 16'(bus.done), 16'd0);
    do_add(16'h0004, 16'h0003, 16'h0007);

    do_add(16'hFFFF, 16'h0001, 16'h0000);
    do_mul(16'h0100, 16'h0100, 16'h0000, 1'b0);
    do_mul(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);

    // Add request during a multiply must be dropped.
    do_mul(16'h0060, 16'h0003, 16'h0120, 1'b1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1;
    bus.h     = OP_MUL;
    bus.a     = 16'h0007;
    bus.b     = 16'h0009;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("abort_busy_pre", 16'(bus.busy), 16'd1);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_result", bus.result, 16'h0000);
    check("abort_busy", 16'(bus.busy), 16'd0);
    check("abort_done", 16'(bus.done), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", 16'(bus.done), 16'd0);
    end
    check("abort_result_hold", bus.result, 16'h0000);
    do_add(16'h0010, 16'h0005, 16'h0015);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
